// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: pin synchronizers, 16-bit frame assembly, valid/ready command slot.
// Optional macro SPI_FRAME_RX_WRITE_ONLY_EN: silently drop correctly sized read frames.
module spi_frame_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_rw,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic [3:0] err_cnt,
  output logic [3:0] ovr_cnt
);

`ifdef SPI_FRAME_RX_WRITE_ONLY_EN
  localparam bit WR_ONLY = 1'b1;
`else
  localparam bit WR_ONLY = 1'b0;
`endif
  localparam int AW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;

  state_t                  state, state_nx;
  logic [SYNC_STAGES-1:0]  sclk_sync, copi_sync, ncs_sync;
  logic                    d_sclk, d_ncs;
  logic                    s_sclk, s_copi, s_ncs;
  logic                    sclk_rise, ncs_fall, ncs_rise;
  logic [FRAME_BITS-1:0]   sr;
  logic [4:0]              bit_cnt;
  logic [AW-1:0]           arm_cnt;
  logic                    armed;
  logic                    clr, do_shift, commit, err_inc, ovr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      d_sclk    <= 1'b0;
      d_ncs     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      d_sclk    <= s_sclk;
      d_ncs     <= s_ncs;
    end
  end

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_copi    = copi_sync[SYNC_STAGES-1];
  assign s_ncs     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~d_sclk;
  assign ncs_fall  = ~s_ncs & d_ncs;
  assign ncs_rise  = s_ncs & ~d_ncs;

  // Synchronizer reset values are not real pin samples; ARM waits until the
  // chain has been refilled before trusting s_ncs, so a frame in flight at
  // reset release is skipped instead of being picked up halfway.
  assign armed = (arm_cnt == AW'(SYNC_STAGES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARM;
      arm_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    do_shift = 1'b0;
    commit   = 1'b0;
    err_inc  = 1'b0;
    ovr_inc  = 1'b0;
    unique case (state)
      ARM:  if (armed && s_ncs) state_nx = IDLE;
      IDLE: if (ncs_fall) begin
        clr      = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        // ncs_rise wins over a coincident sclk_rise: the frame is already over
        if (ncs_rise) begin
          state_nx = IDLE;
          if (bit_cnt == 5'(FRAME_BITS)) begin
            if (!(WR_ONLY && !sr[FRAME_BITS-1])) begin
              if (!cmd_valid || cmd_ready) commit  = 1'b1;
              else                         ovr_inc = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
          end
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end
      end
      default: state_nx = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      sr <= {sr[FRAME_BITS-2:0], s_copi};
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
    end else if (commit) begin
      cmd_valid <= 1'b1;
      cmd_rw    <= sr[FRAME_BITS-1];
      cmd_addr  <= sr[FRAME_BITS-2 -: 7];
      cmd_data  <= sr[7:0];
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      ovr_cnt <= '0;
    end else begin
      if (err_inc && err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
      if (ovr_inc && ovr_cnt != 4'hF) ovr_cnt <= ovr_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: bit-banged SPI frames, queue of expected commands.
module tb_spi_frame_rx;
  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs, cmd_ready;
  logic       cmd_valid, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [3:0] err_cnt, ovr_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] sb[$];

  spi_frame_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  // leaves ncs just raised; caller decides what to do in the commit window
  task automatic spi_frame(input logic [31:0] val, input int n);
    ncs = 1'b0;
    tick(4);
    spi_bits(val, n);
    tick(4);
    ncs = 1'b1;
  endtask

  // handshakes are sampled mid-cycle; inputs only move 2ns after posedge
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) chk("spurious_cmd", {cmd_rw, cmd_addr, cmd_data}, 32'hDEAD);
      else                chk("cmd", {cmd_rw, cmd_addr, cmd_data}, sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; cmd_ready = 1'b1;
    tick(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_rw", cmd_rw, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ovr", ovr_cnt, 0);
    rst = 1'b0;
    tick(6);

    // single write, latency 3 clk from nCS rise
    sb.push_back(16'h8104);
    spi_frame(32'h8104, 16);
    tick(2);
    chk("lat_edge2", cmd_valid, 0);
    tick(1);
    chk("lat_edge3", cmd_valid, 1);
    tick(1);
    chk("pulse_end", cmd_valid, 0);
    chk("sw_err", err_cnt, 0);
    chk("sw_ovr", ovr_cnt, 0);
    tick(4);

    // short and long frames
    spi_frame(32'h4001, 15);
    tick(6);
    spi_frame(32'h18101, 17);
    tick(6);
    chk("bad_len_err", err_cnt, 2);
    chk("bad_len_valid", cmd_valid, 0);

    // overrun with held command
    cmd_ready = 1'b0;
    sb.push_back(16'h8001);
    spi_frame(32'h8001, 16);
    tick(6);
    spi_frame(32'h80FF, 16);
    tick(6);
    chk("hold_valid", cmd_valid, 1);
    chk("hold_data", cmd_data, 8'h01);
    chk("ovr_one", ovr_cnt, 1);
    cmd_ready = 1'b1;
    tick(1);
    chk("drain_valid", cmd_valid, 0);
    tick(4);

    // consume and commit in the same cycle
    cmd_ready = 1'b0;
    sb.push_back(16'h8A11);
    spi_frame(32'h8A11, 16);
    tick(6);
    sb.push_back(16'h8B22);
    spi_frame(32'h8B22, 16);
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("sim_valid", cmd_valid, 1);
    chk("sim_data", cmd_data, 8'h22);
    chk("sim_ovr", ovr_cnt, 1);
    cmd_ready = 1'b1;
    tick(4);
    chk("sim_drained", cmd_valid, 0);

    // reset mid-frame, then ARM skips the remainder
    ncs = 1'b0;
    tick(4);
    spi_bits(32'h81, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    spi_bits(32'h04, 8);
    tick(4);
    ncs = 1'b1;
    tick(8);
    chk("arm_err", err_cnt, 0);
    chk("arm_valid", cmd_valid, 0);
    sb.push_back(16'h8105);
    spi_frame(32'h8105, 16);
    tick(8);

    // read frame
`ifndef SPI_FRAME_RX_WRITE_ONLY_EN
    sb.push_back(16'h0230);
`endif
    spi_frame(32'h0230, 16);
    tick(8);
    chk("rd_err", err_cnt, 0);
    chk("rd_ovr", ovr_cnt, 0);

    // error counter saturation
    for (int i = 0; i < 20; i++) begin
      spi_frame(32'h5, 3);
      tick(5);
      if (i == 13) chk("err_14", err_cnt, 14);
    end
    chk("err_sat", err_cnt, 15);
    chk("sat_ovr", ovr_cnt, 0);

    tick(10);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Front-end receiver for the onboarding SPI register interface. It synchronizes the raw SCLK/COPI/nCS pins into the `clk` domain and assembles 16-bit mode-0 frames, MSB first. Each complete frame is presented as one command (rw, address, data) on a valid/ready port for the register bank that drives the output-enable, PWM-enable and duty-cycle registers. It also reports malformed frames and overruns through saturating counters.

## Interface
- `FRAME_BITS`, 16: SCLK rising edges in a valid frame; bit 15 is rw, bits 14:8 are addr, bits 7:0 are data.
- `SYNC_STAGES`, 2: flops in each pin synchronizer; minimum 2.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: SPI clock pin, asynchronous.
- `copi` input 1: SPI data pin, asynchronous.
- `ncs` input 1: SPI chip select, active low, asynchronous.
- `cmd_valid` output 1: a command is held in the output slot.
- `cmd_ready` input 1: the consumer accepts the command on `clk` when `cmd_valid & cmd_ready`.
- `cmd_rw` output 1: frame bit 15 (1 = write).
- `cmd_addr` output 7: frame bits 14:8.
- `cmd_data` output 8: frame bits 7:0.
- `err_cnt` output 4: malformed-frame count, saturates at 15.
- `ovr_cnt` output 4: dropped-frame (overrun) count, saturates at 15.

## Operation
- **Synchronizers.** Each pin passes through `SYNC_STAGES` flops, then one extra delay flop for edge detection.
  - Sync reset values: sclk 0, copi 0, ncs 1.
- **Edge strobes.** Detection is combinational on synchronized values.
  - sclk_rise = s_sclk & ~d_sclk.
  - ncs_fall = ~s_ncs & d_ncs.
  - ncs_rise = s_ncs & ~d_ncs.
- **FSM states:**
  - ARM: entered on reset. Waits for s_ncs = 1, then goes to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on ncs_fall, clear the shift register and the 5-bit bit counter, then go to SHIFT.
  - SHIFT: on each sclk_rise, shift s_copi into the LSB and increment the counter. The counter saturates at 31.
  - SHIFT, on ncs_rise: go to IDLE and evaluate the frame.
    - counter == `FRAME_BITS`: attempt commit.
    - any other count: increment `err_cnt` and discard.
- **Commit.**
  - If the slot is empty, or is being consumed this same cycle (`cmd_valid & cmd_ready`): load `cmd_rw`, `cmd_addr`, `cmd_data` and assert `cmd_valid` at the next edge.
  - Otherwise: keep the held command unchanged, drop the new frame and increment `ovr_cnt`.
- **Slot handshake.**
  - `cmd_valid` clears on `cmd_valid & cmd_ready` unless a commit reloads it in the same cycle.
  - Held `cmd_*` fields stay stable while `cmd_valid` is 1 and `cmd_ready` is 0.
- **Edge coincidence.** An sclk_rise in the same cycle as ncs_rise is not shifted. The frame ends at ncs_rise.
- **Counters.** Both counters saturate and never wrap. They clear only on `rst`.
- **Reset values.** All outputs are 0: `cmd_valid`=0, `cmd_rw`=0, `cmd_addr`=0, `cmd_data`=0, `err_cnt`=0, `ovr_cnt`=0. The FSM starts in ARM.
- **Reset mid-frame.** Partial frame data is lost. A held, unconsumed command is lost.

## Timing
- **Pin to strobe.** A pin change is visible in s_* after `SYNC_STAGES` clk edges. The strobe is combinational in that same cycle.
- **Commit latency.** `cmd_valid` rises `SYNC_STAGES`+1 clk edges after the nCS rising edge at the pin (3 with the default).
- **SPI clock limits.**
  - SCLK high time ≥ 3 clk periods and low time ≥ 3 clk periods.
  - SCLK frequency ≤ clk/8.
- **nCS limits.**
  - nCS falling edge to first SCLK rise ≥ 3 clk periods.
  - Last SCLK fall to nCS rise ≥ 3 clk periods.
  - nCS high time between frames ≥ 4 clk periods.
- **COPI setup.** COPI must be stable ≥ 3 clk periods before each SCLK rise.
- **Back-to-back frames.** Throughput is one command per frame. With `cmd_ready` held at 1, back-to-back frames never overrun.

## Configuration
- `SPI_FRAME_RX_WRITE_ONLY_EN`
  - **Defined:** a correctly sized frame with bit 15 = 0 (read) is discarded silently. It does not commit, does not count as an error and does not count as an overrun. `cmd_rw` is always 1 when `cmd_valid` = 1.
  - **Undefined:** read frames commit like writes, with `cmd_rw` = 0.

## Test plan
- **Single write.** `cmd_ready`=1; send frame 0x8104 (write, addr 0x01, data 0x04). Required: one-cycle `cmd_valid` pulse 3 clk after nCS rise, with `cmd_rw`=1, `cmd_addr`=0x01, `cmd_data`=0x04. `err_cnt`=0 and `ovr_cnt`=0.
- **Short and long frames.** Send 15-bit frame, then 17-bit frame. Required: no `cmd_valid`; `err_cnt`=2.
- **Overrun and hold stability.** `cmd_ready`=0; send 0x8001 then 0x80FF. Required: held command stays `cmd_data`=0x01; `ovr_cnt`=1. Then raise `cmd_ready`: handshake completes with data 0x01 and `cmd_valid` drops.
- **Simultaneous consume and commit.** `cmd_ready` pulsed in the cycle a new frame commits. Required: the new frame loads; `cmd_valid` stays 1; `ovr_cnt` is unchanged.
- **Reset mid-frame and ARM.** Assert `rst` after 8 SCLK edges with nCS held low; release it; finish the frame. Required: no command and `err_cnt`=0. The next full frame commits normally.
- **Read frames and saturation.** Send read frame 0x0230. Required: commits with `cmd_rw`=0 when `SPI_FRAME_RX_WRITE_ONLY_EN` is undefined; ignored when it is defined. Then send 20 malformed frames: `err_cnt` holds at 15.
